// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding,
// forward-select codes, default multiply latency and the register-match rule.
package hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam int unsigned MUL_LAT_DEFAULT = 4;

    // A producer matches a consumer source only when it really writes a
    // register other than $0.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic       wr,
                                       input logic [4:0] rs);
        return wr && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare logic: selects the EX operand source for Rs and Rt,
// giving EX/MEM priority over MEM/WB.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // Per-operand source select, newest producer first.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (reg_match(mem_rd, mem_reg_write, ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (reg_match(wb_rd, wb_reg_write, ex_rs)) begin
            fwd_a = FWD_WB;
        end
        if (reg_match(mem_rd, mem_reg_write, ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (reg_match(wb_rd, wb_reg_write, ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, branch flush,
// multi-cycle multiply hold, operand forwarding and a stall-cycle counter.
// Build option: define FORWARD_EN to enable forwarding (only load-use then
// stalls); otherwise Forward* is 00 and any EX/MEM producer match stalls.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  EX_Rs,
    input  logic [4:0]  EX_Rt,
    input  logic [4:0]  EX_Rd,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic        EX_IsMul,
    input  logic [4:0]  MEM_Rd,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  WB_Rd,
    input  logic        WB_RegWrite,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXWrite,
    output logic        IDEXBubble,
    output logic        EXMEMBubble,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic [15:0] StallCycles
);

    // The first EX cycle happens in RUN and the release cycle at cnt=0,
    // so the counter covers the remaining MUL_LAT-2 cycles.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        ld_use;
    logic        raw_stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    fwd_unit u_fwd (
        .ex_rs         (EX_Rs),
        .ex_rt         (EX_Rt),
        .mem_rd        (MEM_Rd),
        .mem_reg_write (MEM_RegWrite),
        .wb_rd         (WB_Rd),
        .wb_reg_write  (WB_RegWrite),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Data-hazard detection on the ID-stage sources.
    always_comb begin
        ld_use = EX_MemRead &&
                 (reg_match(EX_Rd, EX_RegWrite, ID_Rs) ||
                  reg_match(EX_Rd, EX_RegWrite, ID_Rt));
`ifdef FORWARD_EN
        raw_stall = ld_use;
`else
        raw_stall = ld_use ||
                    reg_match(EX_Rd,  EX_RegWrite,  ID_Rs) ||
                    reg_match(EX_Rd,  EX_RegWrite,  ID_Rt) ||
                    reg_match(MEM_Rd, MEM_RegWrite, ID_Rs) ||
                    reg_match(MEM_Rd, MEM_RegWrite, ID_Rt);
`endif
    end

`ifdef FORWARD_EN
    // Forward selects straight from the compare unit, forced to regfile in reset.
    always_comb begin
        ForwardA = Rst ? FWD_RF : fwd_a;
        ForwardB = Rst ? FWD_RF : fwd_b;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_a, fwd_b};

    // Without forwarding every operand comes from the register file.
    always_comb begin
        ForwardA = FWD_RF;
        ForwardB = FWD_RF;
    end
`endif

    // Next-state and pipeline-control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        if (Rst) begin
            state_d     = RUN;
            cnt_d       = '0;
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXBubble  = 1'b1;
            EXMEMBubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (EX_IsMul) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMBubble = 1'b1;
                        cnt_d       = MUL_CNT_INIT;
                        state_d     = MUL_WAIT;
                    end else if (BranchTaken) begin
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                    end else if (raw_stall) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    // Branches cannot resolve while the multiply owns EX.
                    if (cnt_q != 4'd0) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMBubble = 1'b1;
                        cnt_d       = cnt_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles with the PC held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign StallCycles = stall_cnt_q;

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, EX-stage occupancy in cycles of a multi-cycle multiply (legal range 2..16).
REQ-002 SHALL have port Clk  in  1  sole clock; all state updates on posedge Clk.
REQ-003 SHALL have port Rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port ID_Rs  in  5  source register 1 of the instruction in ID.
REQ-005 SHALL have port ID_Rt  in  5  source register 2 of the instruction in ID.
REQ-006 SHALL have port EX_Rs  in  5  source register 1 of the instruction in EX.
REQ-007 SHALL have port EX_Rt  in  5  source register 2 of the instruction in EX.
REQ-008 SHALL have port EX_Rd  in  5  destination register of the instruction in EX.
REQ-009 SHALL have port EX_RegWrite  in  1  instruction in EX writes a register.
REQ-010 SHALL have port EX_MemRead  in  1  instruction in EX is a load.
REQ-011 SHALL have port EX_IsMul  in  1  instruction in EX is a multi-cycle multiply.
REQ-012 SHALL have port MEM_Rd  in  5  EX/MEM destination register.
REQ-013 SHALL have port MEM_RegWrite  in  1  EX/MEM register-write control.
REQ-014 SHALL have port WB_Rd  in  5  MEM/WB destination register (R_destination_out).
REQ-015 SHALL have port WB_RegWrite  in  1  MEM/WB register-write control (RegWrite_out).
REQ-016 SHALL have port BranchTaken  in  1  branch resolved taken in EX.
REQ-017 SHALL have port PCWrite  out  1  PC load enable.
REQ-018 SHALL have port IFIDWrite  out  1  IF/ID load enable.
REQ-019 SHALL have port IFIDFlush  out  1  clear IF/ID to a NOP.
REQ-020 SHALL have port IDEXWrite  out  1  ID/EX load enable.
REQ-021 SHALL have port IDEXBubble  out  1  zero ID/EX control fields on load.
REQ-022 SHALL have port EXMEMBubble  out  1  zero EX/MEM control fields on load.
REQ-023 SHALL have ports ForwardA and ForwardB  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-024 SHALL have port StallCycles  out  16  count of cycles with PCWrite=0.

Function
REQ-025 SHALL implement FSM states RUN and MUL_WAIT, with a 4-bit down-counter cnt.
REQ-026 In RUN with no hazard, outputs SHALL be PCWrite=IFIDWrite=IDEXWrite=1, all flush/bubble outputs 0.
REQ-027 Register-match SHALL require Rd!=0 and the matching RegWrite=1; register 0 never matches.
REQ-028 Load-use stall (RUN, EX_MemRead, EX_Rd equals ID_Rs or ID_Rt) SHALL drive PCWrite=IFIDWrite=0 and IDEXBubble=1 for exactly 1 cycle.
REQ-029 BranchTaken in RUN SHALL drive IFIDFlush=1, IDEXBubble=1, PCWrite=1, overriding any load-use or RAW stall that cycle.
REQ-030 RUN with EX_IsMul=1 SHALL hold PC, IF/ID and ID/EX (write enables 0), set EXMEMBubble=1, and load cnt=MUL_LAT-2 with next state MUL_WAIT.
REQ-031 MUL_WAIT with cnt>0 SHALL keep the same holds and decrement cnt; with cnt=0 it SHALL release all holds, set EXMEMBubble=0 and return to RUN, giving MUL_LAT total EX cycles.
REQ-032 BranchTaken SHALL be ignored in MUL_WAIT.
REQ-033 Forwarding SHALL be ForwardA=10 when the MEM match is on EX_Rs, else 01 when the WB match is on EX_Rs, else 00; ForwardB SHALL be identical on EX_Rt; EX/MEM has priority over MEM/WB.
REQ-034 StallCycles SHALL increment in each non-reset cycle with PCWrite=0 and saturate at 0xFFFF.

Reset
REQ-035 While Rst=1, state SHALL be RUN, cnt=0, StallCycles=0, PCWrite=IFIDWrite=IDEXWrite=0, IFIDFlush=IDEXBubble=EXMEMBubble=1, Forward*=00; reset during MUL_WAIT SHALL abandon the multiply.

Configuration
REQ-036 With FORWARD_EN defined, forwarding per REQ-033 SHALL apply and only the load-use hazard SHALL stall; without it, Forward* SHALL be tied 00 and any EX or MEM match on ID_Rs/ID_Rt SHALL stall as in REQ-028, with no stall for a WB match (regfile writes before it reads).

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the forward-select constants (FWD_RF=00, FWD_MEM=10, FWD_WB=01) and MUL_LAT_DEFAULT=4; sub-module fwd_unit SHALL hold the forwarding compare logic.

Verification
REQ-038 Load to $t0 in EX, ID reads $t0 -> one stall cycle (PCWrite=0, IDEXBubble=1), StallCycles 0->1, then ForwardA=01.
REQ-039 ADD writes $5 in MEM, EX reads $5 on Rs and Rt -> ForwardA=ForwardB=10; with a WB match also on $5, still 10.
REQ-040 EX_IsMul, MUL_LAT=4 -> PCWrite=0 for 3 cycles, EXMEMBubble=0 on the 4th, StallCycles=3.
REQ-041 Load-use and BranchTaken asserted together -> IFIDFlush=1, PCWrite=1, no stall counted; Rd=0 writes never forward.
REQ-042 Rst asserted in the 2nd MUL_WAIT cycle -> next cycle RUN, StallCycles=0; without FORWARD_EN, an EX match -> stall, Forward*=00.
